// File: rtl/jtag_types_pkg.sv
// -----------------------------------------------------------------------------
// jtag_types_pkg
// Shared types and constants for the JTAG TAP slice.
//   state_t        : 16 TAP controller states, 4-bit encoding (classic 1149.1
//                    encoding, so a state value reads the same on a logic analyser
//                    as on most vendor TAPs).
//   BYPASS_OPCODE  : all-ones opcode, sliced to the IR width by the user.
//   IR_CAPTURE     : value loaded into the IR shift stage in Capture-IR ({0..0,01}).
// -----------------------------------------------------------------------------
package jtag_types_pkg;

    typedef enum logic [3:0] {
        EX2_DR = 4'h0,
        EX1_DR = 4'h1,
        SH_DR  = 4'h2,
        PAU_DR = 4'h3,
        SEL_IR = 4'h4,
        UPD_DR = 4'h5,
        CAP_DR = 4'h6,
        SEL_DR = 4'h7,
        EX2_IR = 4'h8,
        EX1_IR = 4'h9,
        SH_IR  = 4'hA,
        PAU_IR = 4'hB,
        RTI    = 4'hC,
        UPD_IR = 4'hD,
        CAP_IR = 4'hE,
        TLR    = 4'hF
    } state_t;

    localparam int                      IR_MAX_WIDTH  = 32;
    localparam logic [IR_MAX_WIDTH-1:0] BYPASS_OPCODE = '1;
    localparam logic [IR_MAX_WIDTH-1:0] IR_CAPTURE    = 32'h0000_0001;

endpackage

// File: rtl/jtag_tap_fsm.sv
// -----------------------------------------------------------------------------
// jtag_tap_fsm
// IEEE 1149.1 TAP controller: state register plus next-state logic only.
// Ports:
//   TCK   in   test clock (state advances on posedge)
//   TRST  in   asynchronous active-low reset, forces TLR
//   TMS   in   mode select
//   state out  current controller state
// -----------------------------------------------------------------------------
module jtag_tap_fsm
    import jtag_types_pkg::*;
(
    input  logic   TCK,
    input  logic   TRST,
    input  logic   TMS,
    output state_t state
);

    state_t state_reg;
    state_t state_next;

    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) begin
            state_reg <= TLR;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            TLR:     state_next = TMS ? TLR    : RTI;
            RTI:     state_next = TMS ? SEL_DR : RTI;
            SEL_DR:  state_next = TMS ? SEL_IR : CAP_DR;
            CAP_DR:  state_next = TMS ? EX1_DR : SH_DR;
            SH_DR:   state_next = TMS ? EX1_DR : SH_DR;
            EX1_DR:  state_next = TMS ? UPD_DR : PAU_DR;
            PAU_DR:  state_next = TMS ? EX2_DR : PAU_DR;
            EX2_DR:  state_next = TMS ? UPD_DR : SH_DR;
            UPD_DR:  state_next = TMS ? SEL_DR : RTI;
            SEL_IR:  state_next = TMS ? TLR    : CAP_IR;
            CAP_IR:  state_next = TMS ? EX1_IR : SH_IR;
            SH_IR:   state_next = TMS ? EX1_IR : SH_IR;
            EX1_IR:  state_next = TMS ? UPD_IR : PAU_IR;
            PAU_IR:  state_next = TMS ? EX2_IR : PAU_IR;
            EX2_IR:  state_next = TMS ? UPD_IR : SH_IR;
            UPD_IR:  state_next = TMS ? SEL_DR : RTI;
            default: state_next = TLR;
        endcase
    end

    assign state = state_reg;

endmodule

// File: rtl/jtag_tap_core.sv
// -----------------------------------------------------------------------------
// jtag_tap_core
// TAP controller with instruction register, BYPASS and (optional) IDCODE data
// registers, one-hot user DR selects and a TDO mux retimed on negedge TCK.
// Build option: define TAP_IDCODE_EN to include the 32-bit IDCODE register;
// otherwise IDCODE_OPCODE decodes as BYPASS and the reset instruction is all ones.
// Ports:
//   TCK, TRST(active-low async), TMS, TDI   JTAG pin inputs
//   TDO, tdo_oe                             serial out / enable, updated on negedge
//   state                                   current TAP state
//   instr                                   active instruction
//   dr_capture/dr_shift/dr_update           global DR state strobes
//   usr_sel                                 one-hot user DR select
//   usr_tdo                                 serial LSB from each user DR
// -----------------------------------------------------------------------------
module jtag_tap_core
    import jtag_types_pkg::*;
#(
    parameter int                  IR_WIDTH        = 4,
    parameter int                  NUM_USR_DR      = 2,
    parameter logic [IR_WIDTH-1:0] USR_OPCODE_BASE = 4'h8,
    parameter logic [IR_WIDTH-1:0] IDCODE_OPCODE   = 4'h1,
    parameter logic [31:0]         IDCODE_VAL      = 32'h1000_0A6F
) (
    input  logic                  TCK,
    input  logic                  TRST,
    input  logic                  TMS,
    input  logic                  TDI,
    output logic                  TDO,
    output logic                  tdo_oe,
    output state_t                state,
    output logic [IR_WIDTH-1:0]   instr,
    output logic                  dr_capture,
    output logic                  dr_shift,
    output logic                  dr_update,
    output logic [NUM_USR_DR-1:0] usr_sel,
    input  logic [NUM_USR_DR-1:0] usr_tdo
);

`ifdef TAP_IDCODE_EN
    localparam logic [IR_WIDTH-1:0] RESET_INSTR = IDCODE_OPCODE;
`else
    localparam logic [IR_WIDTH-1:0] RESET_INSTR = BYPASS_OPCODE[IR_WIDTH-1:0];
`endif
    localparam logic [IR_WIDTH-1:0] IR_CAP_VAL = IR_CAPTURE[IR_WIDTH-1:0];

    state_t              state_w;
    logic [IR_WIDTH-1:0] ir_sr_reg;
    logic [IR_WIDTH-1:0] instr_reg;
    logic                bypass_reg;
    logic                tdo_reg;
    logic                tdo_oe_reg;
    logic                sel_idcode;
    logic                sel_usr;
    logic                sel_bypass;
    logic                idcode_lsb;
    logic                usr_bit;
    logic                tdo_src;

    jtag_tap_fsm u_fsm (
        .TCK   (TCK),
        .TRST  (TRST),
        .TMS   (TMS),
        .state (state_w)
    );

    // Instruction shift stage and the active instruction it feeds.
    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) begin
            ir_sr_reg <= '0;
        end else if (state_w == CAP_IR) begin
            ir_sr_reg <= IR_CAP_VAL;
        end else if (state_w == SH_IR) begin
            ir_sr_reg <= {TDI, ir_sr_reg[IR_WIDTH-1:1]};
        end
    end

    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) begin
            instr_reg <= RESET_INSTR;
        end else if (state_w == TLR) begin
            instr_reg <= RESET_INSTR;
        end else if (state_w == UPD_IR) begin
            instr_reg <= ir_sr_reg;
        end
    end

    // User DR decode: one select line per consecutive opcode from the base.
    for (genvar gi = 0; gi < NUM_USR_DR; gi++) begin : g_usr_sel
        localparam logic [IR_WIDTH-1:0] USR_OPC = IR_WIDTH'(int'(USR_OPCODE_BASE) + gi);
        assign usr_sel[gi] = (instr_reg == USR_OPC);
    end

    assign sel_usr    = |usr_sel;
    assign usr_bit    = |(usr_tdo & usr_sel);
    assign sel_bypass = !sel_idcode && !sel_usr;

`ifdef TAP_IDCODE_EN
    logic [31:0] idcode_reg;

    // IDCODE wins over a user DR if the opcodes were ever configured to collide.
    assign sel_idcode = (instr_reg == IDCODE_OPCODE);
    assign idcode_lsb = idcode_reg[0];

    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) begin
            idcode_reg <= '0;
        end else if (sel_idcode && state_w == CAP_DR) begin
            idcode_reg <= IDCODE_VAL;
        end else if (sel_idcode && state_w == SH_DR) begin
            idcode_reg <= {TDI, idcode_reg[31:1]};
        end
    end
`else
    logic unused_idcode;

    assign sel_idcode    = 1'b0;
    assign idcode_lsb    = 1'b0;
    assign unused_idcode = ^{IDCODE_VAL, IDCODE_OPCODE};
`endif

    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) begin
            bypass_reg <= 1'b0;
        end else if (sel_bypass && state_w == CAP_DR) begin
            bypass_reg <= 1'b0;
        end else if (sel_bypass && state_w == SH_DR) begin
            bypass_reg <= TDI;
        end
    end

    always_comb begin
        tdo_src = 1'b0;
        if (state_w == SH_IR) begin
            tdo_src = ir_sr_reg[0];
        end else if (state_w == SH_DR) begin
            if (sel_idcode) begin
                tdo_src = idcode_lsb;
            end else if (sel_usr) begin
                tdo_src = usr_bit;
            end else begin
                tdo_src = bypass_reg;
            end
        end
    end

    // Retiming on the falling edge gives the board half a TCK of hold on TDO.
    always_ff @(negedge TCK or negedge TRST) begin
        if (!TRST) begin
            tdo_reg    <= 1'b0;
            tdo_oe_reg <= 1'b0;
        end else begin
            tdo_reg    <= tdo_src;
            tdo_oe_reg <= (state_w == SH_IR) || (state_w == SH_DR);
        end
    end

    assign state      = state_w;
    assign instr      = instr_reg;
    assign TDO        = tdo_reg;
    assign tdo_oe     = tdo_oe_reg;
    assign dr_capture = (state_w == CAP_DR);
    assign dr_shift   = (state_w == SH_DR);
    assign dr_update  = (state_w == UPD_DR);

endmodule
